// File: rtl/itype_pkg.sv
// Shared encodings for the RV32I OP-IMM issue/control path.
package itype_pkg;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_XORI = 3'b100;
  localparam logic [2:0] F3_SRXI = 3'b101;
  localparam logic [2:0] F3_ORI  = 3'b110;
  localparam logic [2:0] F3_ANDI = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  // One-hot ALU operation, bit order matches the enable outputs
  typedef logic [6:0] op_t;
  localparam op_t OP_NONE = 7'b0000000;
  localparam op_t OP_ADDI = 7'b0000001;
  localparam op_t OP_ORI  = 7'b0000010;
  localparam op_t OP_XORI = 7'b0000100;
  localparam op_t OP_ANDI = 7'b0001000;
  localparam op_t OP_SLLI = 7'b0010000;
  localparam op_t OP_SRLI = 7'b0100000;
  localparam op_t OP_SRAI = 7'b1000000;

endpackage

// File: rtl/itype_decode.sv
// Combinational OP-IMM decoder: instruction word to one-hot op plus illegal flag.
module itype_decode
  import itype_pkg::*;
#(
  parameter logic [6:0] OPCODE = OPC_OPIMM
) (
  input  logic [31:0] instr,
  output op_t         op,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    op      = OP_NONE;
    illegal = 1'b0;
    if (opcode != OPCODE) begin
      illegal = 1'b1;
    end else begin
      case (funct3)
        F3_ADDI: op = OP_ADDI;
        F3_XORI: op = OP_XORI;
        F3_ORI:  op = OP_ORI;
        F3_ANDI: op = OP_ANDI;
        F3_SLLI: begin
          if (funct7 == F7_ZERO) op = OP_SLLI;
          else                   illegal = 1'b1;
        end
        F3_SRXI: begin
          if (funct7 == F7_ZERO)     op = OP_SRLI;
          else if (funct7 == F7_SRA) op = OP_SRAI;
          else                       illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/itype_exec_ctrl.sv
// Issue/control FSM for the I-type ALU: accept, decode, read rs1, execute, write back.
module itype_exec_ctrl #(
  parameter int         XLEN      = 32,
  parameter logic [6:0] OPC_OPIMM = 7'b0010011
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [4:0]      rs1_addr,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rd_data,
  output logic [11:0]     imm,
  output logic            addi_en,
  output logic            ori_en,
  output logic            xori_en,
  output logic            andi_en,
  output logic            slli_en,
  output logic            srli_en,
  output logic            srai_en,
  input  logic [XLEN-1:0] alu_out,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic            busy
);
  import itype_pkg::*;

  state_t     state;
  op_t        dec_op;
  logic       dec_illegal;
  op_t        op_q;
  op_t        en_q;
  logic [4:0] rd_q;

  itype_decode #(.OPCODE(OPC_OPIMM)) u_decode (
    .instr   (instr),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  assign {srai_en, srli_en, slli_en, andi_en, xori_en, ori_en, addi_en} = en_q;

  // The incoming word is decoded at the accept edge so that the illegal pulse and
  // rs1_addr are already registered during DECODE; the synchronous register file
  // then returns rs1_data in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      rs1_addr    <= '0;
      rd_data     <= '0;
      imm         <= '0;
      op_q        <= OP_NONE;
      en_q        <= OP_NONE;
      rd_q        <= '0;
      wb_en       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            rs1_addr    <= instr[19:15];
            imm         <= instr[31:20];
            rd_q        <= instr[11:7];
            op_q        <= dec_op;
            illegal     <= dec_illegal;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          illegal <= 1'b0;
          if (illegal) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            state <= S_READ;
          end
        end
        S_READ: begin
          rd_data <= rs1_data;
          en_q    <= op_q;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          en_q    <= OP_NONE;
          wb_data <= alu_out;
          wb_addr <= rd_q;
          wb_en   <= (rd_q != 5'd0);
          state   <= S_WB;
        end
        S_WB: begin
          wb_en       <= 1'b0;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          en_q        <= OP_NONE;
          wb_en       <= 1'b0;
          illegal     <= 1'b0;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
